// File: rtl/int_controller.sv
// Interrupt controller for the MIPS pipeline core: edge-detects request lines,
// masks and prioritises them, and delivers one vectored interrupt at a time.
module int_controller #(
  parameter int unsigned NUM_IRQ    = 4,
  parameter logic [9:0]  VEC_BASE   = 10'h200,
  parameter logic [9:0]  VEC_STRIDE = 10'h010
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  input  logic               eoi,
  input  logic               available_for_int,
  output logic               int_occured,
  output logic [9:0]         int_pc,
  output logic               in_service,
  output logic [2:0]         active_id,
  output logic [NUM_IRQ-1:0] pending
);

  localparam int unsigned PC_W = 10;
  localparam int unsigned ID_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    SERVICE
  } state_t;

  state_t             state;
  state_t             state_d;
  logic [NUM_IRQ-1:0] irq_q;
  logic [NUM_IRQ-1:0] mask;
  logic [NUM_IRQ-1:0] mask_d;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] eligible;
  logic [NUM_IRQ-1:0] win_onehot;
  logic [NUM_IRQ-1:0] pending_d;
  logic [ID_W-1:0]    win_id;
  logic [ID_W-1:0]    active_id_d;
  logic [PC_W-1:0]    win_pc;
  logic [PC_W-1:0]    int_pc_d;
  logic               issue;
  logic               int_occured_d;
  logic               in_service_d;

  assign rise       = irq & ~irq_q;
  assign eligible   = pending & ~mask;
  // Isolate the lowest set bit: that is the winning request.
  assign win_onehot = eligible & (~eligible + NUM_IRQ'(1));

  always_comb begin
    win_id = '0;
    for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        win_id = ID_W'(i);
      end
    end
  end

  // Vector arithmetic wraps modulo 2^10 by construction.
  assign win_pc = VEC_BASE + PC_W'(win_id) * VEC_STRIDE;

  // Next-state and registered-output values.
  always_comb begin
    state_d       = state;
    issue         = 1'b0;
    int_occured_d = 1'b0;
    int_pc_d      = int_pc;
    active_id_d   = active_id;
    unique case (state)
      IDLE: begin
        if ((|eligible) && available_for_int) begin
          issue         = 1'b1;
          state_d       = ISSUE;
          int_occured_d = 1'b1;
          int_pc_d      = win_pc;
          active_id_d   = win_id;
        end
      end
      ISSUE:   state_d = SERVICE;
      SERVICE: if (eoi) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    in_service_d = (state_d != IDLE);
    // A fresh edge on the line being issued re-pends it.
    pending_d    = (pending & ~(issue ? win_onehot : '0)) | rise;
    mask_d       = mask_we ? mask_wdata : mask;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      irq_q       <= '0;
      mask        <= '1;
      pending     <= '0;
      int_occured <= 1'b0;
      int_pc      <= '0;
      active_id   <= '0;
      in_service  <= 1'b0;
    end else begin
      state       <= state_d;
      irq_q       <= irq;
      mask        <= mask_d;
      pending     <= pending_d;
      int_occured <= int_occured_d;
      int_pc      <= int_pc_d;
      active_id   <= active_id_d;
      in_service  <= in_service_d;
    end
  end

endmodule

// File: tb/tb_int_controller.sv
// Bench for int_controller: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a behavioural model.
module tb_int_controller;

  localparam int unsigned N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] irq;
  logic         mask_we;
  logic [N-1:0] mask_wdata;
  logic         eoi;
  logic         available_for_int;
  logic         int_occured, w_int_occured;
  logic [9:0]   int_pc, w_int_pc;
  logic         in_service, w_in_service;
  logic [2:0]   active_id, w_active_id;
  logic [N-1:0] pending, w_pending;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  int_controller #(.NUM_IRQ(N)) dut (
    .clk(clk), .rst(rst), .irq(irq), .mask_we(mask_we), .mask_wdata(mask_wdata),
    .eoi(eoi), .available_for_int(available_for_int), .int_occured(int_occured),
    .int_pc(int_pc), .in_service(in_service), .active_id(active_id), .pending(pending)
  );

  // Same stimulus, vector base near the top of the PC space.
  int_controller #(.NUM_IRQ(N), .VEC_BASE(10'h3F8), .VEC_STRIDE(10'h010)) dut_w (
    .clk(clk), .rst(rst), .irq(irq), .mask_we(mask_we), .mask_wdata(mask_wdata),
    .eoi(eoi), .available_for_int(available_for_int), .int_occured(w_int_occured),
    .int_pc(w_int_pc), .in_service(w_in_service), .active_id(w_active_id), .pending(w_pending)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: request set, mask, previous irq levels and a service phase.
  bit [N-1:0] m_pend, m_mask, m_prev;
  int         m_phase;   // 0 = free, 1 = pulse cycle, 2 = handler running
  bit         m_occ;
  bit [9:0]   m_pc, m_pc_w;
  bit [2:0]   m_id;
  bit         model_live = 1'b0;
  int         m_win;
  bit [N-1:0] m_new;

  always @(posedge clk) begin
    if (rst) begin
      m_pend = '0; m_mask = '1; m_prev = '0; m_phase = 0;
      m_occ = 1'b0; m_pc = '0; m_pc_w = '0; m_id = '0;
      model_live = 1'b1;
    end else begin
      m_new = irq & ~m_prev;
      m_win = -1;
      for (int i = 0; i < int'(N); i++) begin
        if (m_win < 0 && m_pend[i] && !m_mask[i]) m_win = i;
      end
      m_occ = 1'b0;
      if (m_phase == 0 && m_win >= 0 && available_for_int) begin
        m_occ   = 1'b1;
        m_pend[m_win] = 1'b0;
        m_id    = 3'(m_win);
        m_pc    = 10'(32'h200 + m_win * 16);
        m_pc_w  = 10'(32'h3F8 + m_win * 16);
        m_phase = 1;
      end else if (m_phase == 1) begin
        m_phase = 2;
      end else if (m_phase == 2 && eoi) begin
        m_phase = 0;
      end
      m_pend = m_pend | m_new;
      if (mask_we) m_mask = mask_wdata;
      m_prev = irq;
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      check("int_occured", 32'(int_occured), 32'(m_occ));
      check("int_pc",      32'(int_pc),      32'(m_pc));
      check("wrap_int_pc", 32'(w_int_pc),    32'(m_pc_w));
      check("active_id",   32'(active_id),   32'(m_id));
      check("in_service",  32'(in_service),  32'(m_phase != 0));
      check("pending",     32'(pending),     32'(m_pend));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic finish_service();
    eoi = 1'b1; tick(1); eoi = 1'b0; tick(1);
  endtask

  initial begin
    rst = 1'b1; irq = '0; mask_we = 1'b0; mask_wdata = '0; eoi = 1'b0; available_for_int = 1'b0;
    tick(2);
    rst = 1'b0;
    check("reset_occ", 32'(int_occured), 32'd0);
    check("reset_pc", 32'(int_pc), 32'd0);
    check("reset_in_service", 32'(in_service), 32'd0);
    check("reset_pending", 32'(pending), 32'd0);

    // Basic delivery of irq 2
    mask_we = 1'b1; mask_wdata = 4'b0000; available_for_int = 1'b1;
    tick(1); mask_we = 1'b0; irq = 4'b0100;
    tick(1); check("basic_pending", 32'(pending), 32'h4); check("basic_no_early", 32'(int_occured), 32'd0);
    irq = '0;
    tick(1); check("basic_pulse", 32'(int_occured), 32'd1); check("basic_pc", 32'(int_pc), 32'h220);
    check("basic_id", 32'(active_id), 32'd2); check("basic_cleared", 32'(pending), 32'h0);
    tick(1); check("basic_one_cycle", 32'(int_occured), 32'd0);
    tick(3); check("basic_in_service", 32'(in_service), 32'd1);
    eoi = 1'b1; tick(1); eoi = 1'b0; check("basic_eoi", 32'(in_service), 32'd0);

    // Priority: lines 3 and 1 together
    irq = 4'b1010;
    tick(1); check("prio_pending", 32'(pending), 32'hA); irq = '0;
    tick(1); check("prio_first_pc", 32'(int_pc), 32'h210); check("prio_first_pulse", 32'(int_occured), 32'd1);
    tick(1); eoi = 1'b1;
    tick(1); eoi = 1'b0;
    tick(1); check("prio_second_pulse", 32'(int_occured), 32'd1); check("prio_second_pc", 32'(int_pc), 32'h230);
    check("prio_second_id", 32'(active_id), 32'd3);
    tick(1); finish_service();

    // Mask and availability gating on line 0
    mask_we = 1'b1; mask_wdata = 4'b0001; available_for_int = 1'b0;
    tick(1); mask_we = 1'b0; irq = 4'b0001;
    tick(1); irq = '0;
    for (int c = 0; c < 5; c++) begin
      tick(1); check("gate_pending", 32'(pending[0]), 32'd1); check("gate_no_pulse", 32'(int_occured), 32'd0);
    end
    mask_we = 1'b1; mask_wdata = 4'b0000; available_for_int = 1'b1;
    tick(1); mask_we = 1'b0; check("gate_wait", 32'(int_occured), 32'd0);
    tick(1); check("gate_pulse", 32'(int_occured), 32'd1); check("gate_pc", 32'(int_pc), 32'h200);
    tick(1); finish_service();

    // Vector wrap on the high-base instance
    irq = 4'b0010;
    tick(1); irq = '0;
    tick(1); check("wrap_pulse", 32'(w_int_occured), 32'd1); check("wrap_pc", 32'(w_int_pc), 32'h008);
    tick(1); finish_service();

    // Re-pend on the issuing edge, eoi during ISSUE ignored
    available_for_int = 1'b0; irq = 4'b0001;
    tick(1); irq = '0;
    tick(1); available_for_int = 1'b1; irq = 4'b0001;
    tick(1); check("repend_pulse", 32'(int_occured), 32'd1); check("repend_pending", 32'(pending[0]), 32'd1);
    eoi = 1'b1;
    tick(1); eoi = 1'b0; check("repend_eoi_ignored", 32'(in_service), 32'd1);
    tick(2); check("repend_hold", 32'(in_service), 32'd1); check("repend_no_pulse", 32'(int_occured), 32'd0);
    eoi = 1'b1;
    tick(1); eoi = 1'b0; check("repend_idle", 32'(in_service), 32'd0);
    tick(1); check("repend_second", 32'(int_occured), 32'd1); check("repend_id", 32'(active_id), 32'd0);
    tick(1); finish_service();
    tick(3); check("level_one_request", 32'(in_service), 32'd0); check("level_no_pending", 32'(pending), 32'd0);
    irq = '0;

    // Reset mid-service with lines 3 and 1 pending
    irq = 4'b0100;
    tick(1); irq = '0;
    tick(2); irq = 4'b1010;
    tick(1); irq = '0;
    tick(1); check("rst_pre_pending", 32'(pending), 32'hA); check("rst_pre_service", 32'(in_service), 32'd1);
    rst = 1'b1;
    tick(1); rst = 1'b0;
    check("rst_pending", 32'(pending), 32'd0); check("rst_service", 32'(in_service), 32'd0);
    check("rst_pc", 32'(int_pc), 32'd0); check("rst_id", 32'(active_id), 32'd0);
    irq = 4'b0001;
    tick(1); irq = '0;
    for (int c = 0; c < 4; c++) begin
      tick(1); check("rst_masked", 32'(int_occured), 32'd0); check("rst_masked_pending", 32'(pending), 32'h1);
    end

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 499) == 0);
      for (int b = 0; b < int'(N); b++) begin
        if ($urandom_range(0, 5) == 0) irq[b] = ~irq[b];
      end
      mask_we = ($urandom_range(0, 15) == 0);
      mask_wdata = N'($urandom_range(0, 15)) & N'($urandom_range(0, 15));
      eoi = ($urandom_range(0, 3) == 0);
      available_for_int = ($urandom_range(0, 3) != 0);
      tick(1);
    end
    rst = 1'b0; mask_we = 1'b0; eoi = 1'b0;
    tick(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
